mem_loader: RTL and testbench

Streams matrix rows from a narrow valid/ready source and writes them, one 1050-bit row per write, into the three 350-bit verification memory banks. It is the write side of the row store the signature-verification datapath reads by 10-bit address. The loader assembles 21 input words into a row, issues a one-cycle write strobe with address and data, and repeats for a programmed row count. It then pulses `done`.

---
 rtl/mem_loader_pkg.sv | 10 +
 rtl/row_assembler.sv | 34 +++
 rtl/mem_loader.sv | 79 +++++++
 tb/tb_mem_loader.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared widths, derived word counts and loader state encoding.
package mem_loader_pkg;
  parameter int ADDR_W = 10;
  parameter int DAT_W = 1050;
  parameter int BANK_W = 350;
  parameter int IN_W = 50;
  parameter int WORDS_PER_ROW = DAT_W / IN_W;
  parameter int WORDS_PER_BANK = BANK_W / IN_W;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;
endpackage

// File: rtl/row_assembler.sv
// row_assembler: shifts input words into a row buffer and flags the last word slot.
module row_assembler #(
  parameter int DAT_W = 1050,
  parameter int IN_W = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic [IN_W-1:0]  din,
  output logic [DAT_W-1:0] row,
  output logic             row_full
);
  localparam int WORDS = DAT_W / IN_W;
  localparam int CW = $clog2(WORDS);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DAT_W-1:0] buf_q, buf_d;
  // row_full marks the slot whose handshake completes the row
  always_comb begin
    row_full = cnt_q == CW'(WORDS - 1);
    buf_d = shift_en ? {buf_q[DAT_W-IN_W-1:0], din} : buf_q;
    cnt_d = clr ? '0 : shift_en ? (row_full ? '0 : cnt_q + 1'b1) : cnt_q;
    row = buf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end
endmodule

// File: rtl/mem_loader.sv
// mem_loader: assembles streamed words into rows and writes them to the three-bank row store.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W = mem_loader_pkg::ADDR_W,
  parameter int DAT_W = mem_loader_pkg::DAT_W,
  parameter int BANK_W = mem_loader_pkg::BANK_W,
  parameter int IN_W = mem_loader_pkg::IN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_rows,
  input  logic [IN_W-1:0]   s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DAT_W-1:0]  wdata,
  output logic              busy,
  output logic              done
);
  if (DAT_W % IN_W != 0 || BANK_W % IN_W != 0) begin : g_bad_widths
    $error("mem_loader: DAT_W and BANK_W must be multiples of IN_W");
  end
  state_e state_q, state_d;
  logic [ADDR_W:0] rows_q, rows_d, row_cnt_q, row_cnt_d;
  logic shift_en, row_full, clr;
  logic [DAT_W-1:0] row;
  assign shift_en = s_valid && state_q == FILL;
  assign clr = start && state_q == IDLE;
  row_assembler #(.DAT_W(DAT_W), .IN_W(IN_W)) u_asm (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .shift_en(shift_en),
    .din(s_data),
    .row(row),
    .row_full(row_full)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rows_q <= '0;
      row_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rows_q <= rows_d;
      row_cnt_q <= row_cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    rows_d = rows_q;
    row_cnt_d = row_cnt_q;
    case (state_q)
      IDLE: if (start) begin
        rows_d = num_rows;
        row_cnt_d = '0;
        state_d = num_rows == '0 ? DONE : FILL;
      end
      FILL: if (shift_en && row_full) state_d = WRITE;
      WRITE: begin
        row_cnt_d = row_cnt_q + 1'b1;
        state_d = row_cnt_q == rows_q - 1'b1 ? DONE : FILL;
      end
      DONE: state_d = IDLE;
    endcase
  end
  // every output is a decode of registered state, so s_valid never reaches s_ready
  always_comb begin
    s_ready = state_q == FILL;
    we = state_q == WRITE;
    busy = state_q == FILL || state_q == WRITE;
    done = state_q == DONE;
    waddr = row_cnt_q[ADDR_W-1:0];
    wdata = row;
  end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: table-driven load scenarios plus directed reset and idle sequences.
module tb_mem_loader;
  import mem_loader_pkg::*;
  logic clk = 0, rst = 1, start = 0, s_valid = 0;
  logic [ADDR_W:0] num_rows = '0;
  logic [IN_W-1:0] s_data = '0;
  logic s_ready, we, busy, done;
  logic [ADDR_W-1:0] waddr;
  logic [DAT_W-1:0] wdata;
  int n_chk = 0, n_pass = 0;
  typedef struct {
    int nrows;
    int mode;
    int base;
    int exp_we;
    int exp_words;
  } vec_t;
  vec_t tbl[5];

  mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
  endtask

  task automatic chk_row(input string nm, input logic [DAT_W-1:0] act, input logic [DAT_W-1:0] exp);
    int k;
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      for (k = 0; k < WORDS_PER_ROW - 1; k++)
        if (act[DAT_W-1-k*IN_W -: IN_W] !== exp[DAT_W-1-k*IN_W -: IN_W]) break;
      $display("FAIL %s word %0d act=%0h exp=%0h", nm, k,
               act[DAT_W-1-k*IN_W -: IN_W], exp[DAT_W-1-k*IN_W -: IN_W]);
    end
  endtask

  // word k of a row sits at the top of wdata for k=0 and the bottom for the last word
  function automatic logic [DAT_W-1:0] row_model(input int first);
    logic [DAT_W-1:0] r = '0;
    for (int k = 0; k < WORDS_PER_ROW; k++) r[DAT_W-1-k*IN_W -: IN_W] = IN_W'(first + k);
    return r;
  endfunction

  task automatic run_load(input int nrows, input int mode, input int base, input int exp_we, input int exp_words);
    int nwe = 0, words = 0, cyc = 0, last_we = -10, done_cyc = -1, last_hs = -10;
    bit prev_we = 0;
    @(negedge clk);
    start = 1;
    num_rows = (ADDR_W + 1)'(nrows);
    s_valid = 0;
    @(negedge clk);
    start = 0;
    chk("ready_at_start1", 64'(s_ready), 64'(nrows != 0));
    chk("done_at_start1", 64'(done), 64'(nrows == 0));
    while (done_cyc < 0 && cyc < nrows * 60 + 50) begin
      if (prev_we && !done) chk("ready_after_we", 64'(s_ready), 64'd1);
      prev_we = we;
      if (we) begin
        chk("waddr", 64'(waddr), 64'(nwe));
        chk_row("wdata", wdata, row_model(base + nwe * WORDS_PER_ROW));
        chk("ready_in_write", 64'(s_ready), 64'd0);
        chk("we_latency", 64'(cyc - last_hs), 64'd1);
        nwe++;
        last_we = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        chk("busy_at_done", 64'(busy), 64'd0);
      end else begin
        s_valid = mode == 1 ? (cyc % 2 == 0) : 1'b1;
        s_data = IN_W'(base + words);
        start = mode == 2 && cyc == 500;
        if (start) num_rows = 5;
        if (s_valid && s_ready) begin
          words++;
          last_hs = cyc;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 0;
    if (done_cyc < 0) $display("FAIL done_timeout rows=%0d act=none exp=done", nrows);
    chk("we_count", 64'(nwe), 64'(exp_we));
    chk("words_consumed", 64'(words), 64'(exp_words));
    chk("done_cycle", 64'(done_cyc), nrows == 0 ? 64'd0 : 64'(last_we + 1));
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    s_valid = 0;
  endtask

  initial begin
    tbl[0] = '{1, 0, 1, 1, 21};
    tbl[1] = '{3, 1, 100, 3, 63};
    tbl[2] = '{0, 0, 0, 0, 0};
    tbl[3] = '{1024, 2, 5000, 1024, 21504};
    tbl[4] = '{2, 1, 77, 2, 42};
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_we_busy_done", 64'({we, busy, done}), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk_row("rst_wdata", wdata, '0);
    rst = 0;
    s_valid = 1;
    for (int i = 0; i < 4; i++) begin
      s_data = IN_W'(i + 33);
      @(negedge clk);
      chk("idle_ready", 64'(s_ready), 64'd0);
    end
    chk_row("idle_wdata", wdata, '0);
    s_valid = 0;
    for (int i = 0; i < 5; i++) begin
      run_load(tbl[i].nrows, tbl[i].mode, tbl[i].base, tbl[i].exp_we, tbl[i].exp_words);
      if (i == 0) begin
        chk("single_top_word", 64'(wdata[DAT_W-1 -: IN_W]), 64'd1);
        chk("single_low_word", 64'(wdata[IN_W-1:0]), 64'd21);
      end
    end
    @(negedge clk);
    start = 1;
    num_rows = 2;
    @(negedge clk);
    start = 0;
    s_valid = 1;
    for (int i = 0; i < 10; i++) begin
      s_data = IN_W'(900 + i);
      @(negedge clk);
    end
    rst = 1;
    s_valid = 0;
    @(negedge clk);
    rst = 0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk_row("midrst_wdata", wdata, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_we", 64'({we, s_ready}), 64'd0);
    end
    run_load(2, 1, 300, 2, 42);
    s_valid = 1;
    for (int i = 0; i < 5; i++) begin
      s_data = IN_W'(7000 + i);
      @(negedge clk);
      chk("post_idle_ready", 64'(s_ready), 64'd0);
    end
    chk_row("post_idle_wdata", wdata, row_model(300 + WORDS_PER_ROW));
    s_valid = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
